// File: rtl/fifo_rd_fwft_stage.sv
// fifo_rd_fwft_stage
//   Read-side output stage of the async FIFO (rclk domain). Turns the FIFO's
//   r_en/empty interface with 1-cycle RAM read latency into a first-word-
//   fall-through valid/ready stream by prefetching into a small local buffer.
//
// Ports
//   rclk        read-domain clock
//   rrst_n      asynchronous active-low reset
//   empty       registered empty flag from the read-pointer handler
//   r_en        read request to the read-pointer handler and RAM
//   fifo_rdata  RAM read data, valid the cycle after an accepted read
//   m_valid     head word available
//   m_ready     consumer accepts the head word
//   m_data      head word
//   buf_count   words currently held in the local buffer
module fifo_rd_fwft_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                               rclk,
    input  logic                               rrst_n,
    input  logic                               empty,
    output logic                               r_en,
    input  logic [DATA_WIDTH-1:0]              fifo_rdata,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [DATA_WIDTH-1:0]              m_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     buf_count
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [IDX_W-1:0]      head;
    logic [IDX_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic                  inflight;
    logic                  active;
    logic                  pop;
    logic [CNT_W:0]        credit_used;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

    // The credit check counts the read still in flight, so a landing word
    // always finds a free slot. 'active' holds r_en low while in reset even
    // if empty is already low.
    always_comb begin
        credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        r_en        = active && !empty && (credit_used < (CNT_W+1)'(BUF_DEPTH));
        m_valid     = (count != '0);
        m_data      = mem[head];
        pop         = m_valid && m_ready;
        buf_count   = count;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            active   <= 1'b0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            active   <= 1'b1;
            inflight <= r_en;
            if (inflight) begin
                mem[tail] <= fifo_rdata;
                tail      <= wrap_inc(tail);
            end
            if (pop) begin
                head <= wrap_inc(head);
            end
            case ({inflight, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_count_bound: assert property (@(posedge rclk) disable iff (!rrst_n)
        count <= CNT_W'(BUF_DEPTH));

    a_no_land_full: assert property (@(posedge rclk) disable iff (!rrst_n)
        !(inflight && count == CNT_W'(BUF_DEPTH)));

endmodule
